rps_round_ctrl: RTL
===================

// Module: rps_round_ctrl
// PURPOSE
// Round controller for the rock-paper-scissors gesture display. Synchronises and
// debounces the three active-low gesture inputs, arms a round on start, arbitrates
// the first qualifying gesture, and latches the result. Drives the common-anode RGB
// LED and reports the winner, replacing per-input async latching with one clocked
// sequencer.
// PARAMETERS
// DEB_CYCLES    16        consecutive low samples needed to accept a press (>=1)
// ROCK_PRESSES  3         rock presses required to register rock (>=1)
// ROUND_TIMEOUT 50000000  cycles in ARMED before the round times out (>=2)
// SHOW_CYCLES   25000000  cycles the result is held before returning to IDLE (>=1)
// PORTS
// clk        in   1  system clock
// rst        in   1  synchronous, active-high reset
// start      in   1  1-cycle pulse, synchronous to clk: arm a new round
// rx_data_1  in   1  scissors gesture, raw async, active-low
// rx_data_2  in   1  paper gesture, raw async, active-low
// rx_data_3  in   1  rock gesture, raw async, active-low
// led_r      out  1  red LED, active-low
// led_g      out  1  green LED, active-low
// led_b      out  1  blue LED, active-low
// winner     out  2  last result: 2=scissors 1=paper 0=rock 3=none/timeout
// round_done out  1  1-cycle pulse when a result (incl. timeout) is latched
// busy       out  1  high in ARMED, SHOW and TOUT
// BEHAVIOUR
// - One clock, one synchronous active-high reset. Everything samples rst on posedge clk.
// - Reset values:
//   - FSM=IDLE; {led_r,led_g,led_b}=3'b000 (white, waiting); winner=2'b11.
//   - round_done=0; busy=0; all counters 0; debouncers treat inputs as high (released).
// - Input path, per channel:
//   - 2-FF synchroniser, then a debounce counter on the synchronised level.
//   - The counter clears while the level is high and saturates at DEB_CYCLES.
//   - A press pulse (1 cycle) is issued when the count reaches DEB_CYCLES.
//   - Exactly one pulse per low period. Glitches shorter than DEB_CYCLES produce no pulse.
//   - Latency from input fall to press pulse = 2 + DEB_CYCLES cycles.
//   - Debouncers run in every state. Presses are only acted on in ARMED.
// - FSM states: IDLE, ARMED, SHOW, TOUT. Registered outputs update 1 cycle after a transition.
// - IDLE:
//   - leds 000. start -> ARMED.
//   - On entry to ARMED, clear rock_cnt and timer.
// - ARMED:
//   - leds 111 (off); timer increments each cycle.
//   - Same-cycle priority (fixed): scissors > paper > rock.
//     - scissors press -> SHOW, winner=2.
//     - else paper press -> SHOW, winner=1.
//     - else rock press with rock_cnt==ROCK_PRESSES-1 -> SHOW, winner=0.
//     - else rock press -> rock_cnt+1.
//   - Otherwise timer==ROUND_TIMEOUT-1 -> TOUT, winner=3. A press in that same cycle wins over timeout.
//   - start in ARMED is ignored.
// - SHOW:
//   - leds by winner: 2 -> 110 (blue), 1 -> 101 (green), 0 -> 011 (red).
//   - round_done pulses in the first SHOW cycle.
//   - Hold SHOW_CYCLES cycles, then -> IDLE. start and presses are ignored.
// - TOUT:
//   - leds 010 (magenta); round_done pulses in the first cycle.
//   - Hold SHOW_CYCLES cycles, then -> IDLE.
// - winner holds its value until the next result or reset.
// - rock_cnt width = clog2(ROCK_PRESSES+1). Timer and hold counter widths come from
//   their parameters. Counters never wrap.
// - rst asserted mid-round (any state) -> full reset values on that edge. No round_done is issued.
// TESTING
// Bench parameters: DEB_CYCLES=4, ROCK_PRESSES=3, ROUND_TIMEOUT=200, SHOW_CYCLES=20.
// - Scissors wins: start; rx_data_1 low for 10 cycles -> round_done 1 cycle after the press;
//   winner=2; leds 110 for 20 cycles, then 000.
// - Rock count: start; three rock lows of 8 cycles each, with 8-cycle gaps -> no result after
//   presses 1-2; winner=0 after press 3; leds 011.
// - Simultaneous: start; rx_data_1..3 fall on the same cycle -> winner=2; a single round_done.
// - Glitch + timeout: start; rx_data_2 low for 3 cycles -> no press. At cycle 200 of ARMED:
//   TOUT, winner=3, leds 010, round_done=1.
// - Reset mid-round: start; 2 rock presses; rst for 1 cycle -> IDLE, leds 000, winner=3.
//   A new start then needs 3 fresh rock presses.
// - Ignored inputs: presses in IDLE, and start/presses during SHOW -> no state or winner
//   change; busy=0 in IDLE.

Source files
------------

// File: rtl/rps_round_ctrl.sv
// Round controller for the rock-paper-scissors gesture display: debounces three
// active-low gesture inputs, arbitrates one result per round and drives the RGB LED.
module rps_round_ctrl #(
    parameter int DEB_CYCLES    = 16,
    parameter int ROCK_PRESSES  = 3,
    parameter int ROUND_TIMEOUT = 50000000,
    parameter int SHOW_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rx_data_1,
    input  logic       rx_data_2,
    input  logic       rx_data_3,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic [1:0] winner,
    output logic       round_done,
    output logic       busy
);

    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int ROCK_W  = $clog2(ROCK_PRESSES + 1);
    localparam int TIMER_W = $clog2(ROUND_TIMEOUT);
    localparam int HOLD_W  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEB_CYCLES);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);
    localparam logic [ROCK_W-1:0]  ROCK_LAST  = ROCK_W'(ROCK_PRESSES - 1);
    localparam logic [ROCK_W-1:0]  ROCK_ONE   = ROCK_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ROUND_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(SHOW_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHOW  = 2'd2,
        ST_TOUT  = 2'd3
    } state_t;

    // Channel order: bit 0 scissors, bit 1 paper, bit 2 rock.
    logic [2:0]         raw_s;
    logic [2:0]         sync1_r;
    logic [2:0]         sync2_r;
    logic [2:0]         press_r;
    logic [DEB_W-1:0]   deb_cnt_r [3];

    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         result_s;
    logic               result_vld_s;
    logic               rock_inc_s;
    logic [TIMER_W-1:0] timer_r;
    logic [ROCK_W-1:0]  rock_cnt_r;
    logic [HOLD_W-1:0]  hold_r;

    logic [2:0]         leds_nxt_s;
    logic [1:0]         winner_nxt_s;
    logic               busy_nxt_s;
    logic               done_nxt_s;

    assign raw_s = {rx_data_3, rx_data_2, rx_data_1};

    // Synchronise and debounce; one press pulse when a low level has lasted DEB_CYCLES samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 3'b111;
            sync2_r <= 3'b111;
            press_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_r[i] <= {DEB_W{1'b0}};
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i]) begin
                    deb_cnt_r[i] <= {DEB_W{1'b0}};
                    press_r[i]   <= 1'b0;
                end else if (deb_cnt_r[i] != DEB_MAX) begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
                    press_r[i]   <= (deb_cnt_r[i] == DEB_LAST);
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i];
                    press_r[i]   <= 1'b0;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and arbitration; only a result-producing press pre-empts the timeout.
    always_comb begin
        state_nxt_s  = state_r;
        result_s     = 2'b11;
        result_vld_s = 1'b0;
        rock_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (press_r[0]) begin
                    state_nxt_s  = ST_SHOW;
                    result_s     = 2'd2;
                    result_vld_s = 1'b1;
                end else if (press_r[1]) begin
                    state_nxt_s  = ST_SHOW;
                    result_s     = 2'd1;
                    result_vld_s = 1'b1;
                end else if (press_r[2] && (rock_cnt_r == ROCK_LAST)) begin
                    state_nxt_s  = ST_SHOW;
                    result_s     = 2'd0;
                    result_vld_s = 1'b1;
                end else if (timer_r == TIMER_LAST) begin
                    state_nxt_s  = ST_TOUT;
                    result_s     = 2'd3;
                    result_vld_s = 1'b1;
                end else begin
                    state_nxt_s = ST_ARMED;
                    rock_inc_s  = press_r[2];
                end
            end
            ST_SHOW, ST_TOUT: begin
                if (hold_r == HOLD_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Round timer, rock tally and result hold counter; each clears outside its own state.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r    <= {TIMER_W{1'b0}};
            rock_cnt_r <= {ROCK_W{1'b0}};
            hold_r     <= {HOLD_W{1'b0}};
        end else begin
            if (state_r == ST_ARMED) begin
                if (timer_r != TIMER_LAST) begin
                    timer_r <= timer_r + TIMER_ONE;
                end else begin
                    timer_r <= timer_r;
                end
                if (rock_inc_s) begin
                    rock_cnt_r <= rock_cnt_r + ROCK_ONE;
                end else begin
                    rock_cnt_r <= rock_cnt_r;
                end
            end else begin
                timer_r    <= {TIMER_W{1'b0}};
                rock_cnt_r <= {ROCK_W{1'b0}};
            end
            if ((state_r == ST_SHOW) || (state_r == ST_TOUT)) begin
                if (hold_r != HOLD_LAST) begin
                    hold_r <= hold_r + HOLD_ONE;
                end else begin
                    hold_r <= hold_r;
                end
            end else begin
                hold_r <= {HOLD_W{1'b0}};
            end
        end
    end

    // Output decode from the upcoming state so registered outputs line up with state_r.
    always_comb begin
        leds_nxt_s = 3'b000;
        busy_nxt_s = 1'b0;
        done_nxt_s = result_vld_s;
        if (result_vld_s) begin
            winner_nxt_s = result_s;
        end else begin
            winner_nxt_s = winner;
        end
        case (state_nxt_s)
            ST_IDLE: begin
                leds_nxt_s = 3'b000;
                busy_nxt_s = 1'b0;
            end
            ST_ARMED: begin
                leds_nxt_s = 3'b111;
                busy_nxt_s = 1'b1;
            end
            ST_SHOW: begin
                busy_nxt_s = 1'b1;
                case (winner_nxt_s)
                    2'd2:    leds_nxt_s = 3'b110;
                    2'd1:    leds_nxt_s = 3'b101;
                    2'd0:    leds_nxt_s = 3'b011;
                    default: leds_nxt_s = 3'b111;
                endcase
            end
            ST_TOUT: begin
                leds_nxt_s = 3'b010;
                busy_nxt_s = 1'b1;
            end
            default: begin
                leds_nxt_s = 3'b000;
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r      <= 1'b0;
            led_g      <= 1'b0;
            led_b      <= 1'b0;
            winner     <= 2'b11;
            round_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            led_r      <= leds_nxt_s[2];
            led_g      <= leds_nxt_s[1];
            led_b      <= leds_nxt_s[0];
            winner     <= winner_nxt_s;
            round_done <= done_nxt_s;
            busy       <= busy_nxt_s;
        end
    end

endmodule
